// File: rtl/wsr_pkg.sv
// Shared definitions for the wait-state RAM: access size codes, FSM states
// and the byte-lane decode used by both the write path and the fault check.
package wsr_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_en = 4'b0001 << off;
            SZ_HALF: lane_en = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ram_lane.sv
// One 8-bit byte lane: synchronous write, registered read that only updates
// when re is pulsed, so the output holds the last read value.
module ram_lane #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/wait_state_ram.sv
// 32-bit byte-addressable RAM with a configurable number of wait states,
// byte/halfword/word accesses and alignment fault reporting.
module wait_state_ram
    import wsr_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  done,
    output logic                  fault
);

    localparam int         WA     = ADDR_WIDTH - 2;
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    state_t state, state_nx;
    logic [3:0] cnt;

    logic                  cap_we;
    logic [1:0]            cap_size;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_wdata;

    logic                  op_we;
    logic [1:0]            op_size;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_wdata;
    logic                  op_fault;
    logic [3:0]            op_lanes;
    logic [31:0]           wshift;

    logic       accept, enter_resp, fault_q;
    logic [3:0] lane_we;
    logic       lane_re;
    logic [1:0] rd_off;
    logic [1:0] rd_size;
    logic [31:0] lanes_q, lanes_sh;

    assign accept = req && ready && !rst;

    // With no wait states the access completes on its acceptance edge, so the
    // live inputs drive the memory; otherwise the captured copy does.
    always_comb begin
        if (state == ST_WAIT) begin
            op_we    = cap_we;
            op_size  = cap_size;
            op_addr  = cap_addr;
            op_wdata = cap_wdata;
        end else begin
            op_we    = we;
            op_size  = size;
            op_addr  = addr;
            op_wdata = wdata;
        end
    end

    assign enter_resp = !rst && ((accept && (WS_CNT == 4'd0)) ||
                                 ((state == ST_WAIT) && (cnt == 4'd1)));
    assign op_fault   = misaligned(op_size, op_addr[1:0]);
    assign op_lanes   = lane_en(op_size, op_addr[1:0]);
    assign wshift     = op_wdata << {op_addr[1:0], 3'b000};
    assign lane_we    = {4{enter_resp && op_we && !op_fault}} & op_lanes;
    assign lane_re    = enter_resp && !op_we && !op_fault;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        ram_lane #(.DEPTH_LOG2(WA)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (lane_we[i]),
            .re    (lane_re),
            .addr  (op_addr[ADDR_WIDTH-1:2]),
            .wdata (wshift[8*i +: 8]),
            .rdata (lanes_q[8*i +: 8])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = (WS_CNT == 4'd0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == 4'd1) state_nx = ST_RESP;
            ST_RESP: begin
                if (accept)
                    state_nx = (WS_CNT == 4'd0) ? ST_RESP : ST_WAIT;
                else
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state != ST_WAIT);
        done  = (state == ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_size  <= SZ_BYTE;
            cap_addr  <= '0;
            cap_wdata <= '0;
            fault_q   <= 1'b0;
            rd_off    <= 2'b00;
            rd_size   <= SZ_WORD;
        end else begin
            if (accept) begin
                cnt       <= WS_CNT;
                cap_we    <= we;
                cap_size  <= size;
                cap_addr  <= addr;
                cap_wdata <= wdata;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp)
                fault_q <= op_fault;
            // Alignment of the lane registers' contents, kept with the data.
            if (lane_re) begin
                rd_off  <= op_addr[1:0];
                rd_size <= op_size;
            end
        end
    end

    assign fault    = done && fault_q;
    assign lanes_sh = lanes_q >> {rd_off, 3'b000};

    always_comb begin
        case (rd_size)
            SZ_BYTE: rdata = {24'h0, lanes_sh[7:0]};
            SZ_HALF: rdata = {16'h0, lanes_sh[15:0]};
            default: rdata = lanes_sh;
        endcase
    end

endmodule

// File: tb/tb_wait_state_ram.sv
// Directed bench: functional sequence on a 1-wait-state instance, throughput
// on 0- and 3-wait-state instances.
module tb_wait_state_ram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [1:0]  r1_size = 2'b10;
    logic [13:0] r1_addr = '0;
    logic [31:0] r1_wdata = '0, r1_rdata;
    logic        r1_ready, r1_done, r1_fault;

    logic        r0_req = 1'b0;
    logic [31:0] r0_rdata;
    logic        r0_ready, r0_done, r0_fault;

    logic        r3_req = 1'b0;
    logic [31:0] r3_rdata;
    logic        r3_ready, r3_done, r3_fault;

    wait_state_ram #(.ADDR_WIDTH(14), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .req(r1_req), .we(r1_we), .size(r1_size),
        .addr(r1_addr), .wdata(r1_wdata), .rdata(r1_rdata),
        .ready(r1_ready), .done(r1_done), .fault(r1_fault));

    wait_state_ram #(.ADDR_WIDTH(14), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req(r0_req), .we(1'b0), .size(2'b10),
        .addr(14'h0), .wdata(32'h0), .rdata(r0_rdata),
        .ready(r0_ready), .done(r0_done), .fault(r0_fault));

    wait_state_ram #(.ADDR_WIDTH(14), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .req(r3_req), .we(1'b0), .size(2'b10),
        .addr(14'h0), .wdata(32'h0), .rdata(r3_rdata),
        .ready(r3_ready), .done(r3_done), .fault(r3_fault));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on dut1; checks latency, fault, rdata at done, and pulse width.
    task automatic acc1(input string tag, input logic w, input logic [1:0] sz,
                        input logic [13:0] a, input logic [31:0] wd,
                        input logic exp_fault, input logic [31:0] exp_rd);
        int  lat;
        bit  seen;
        @(negedge clk);
        r1_req = 1'b1; r1_we = w; r1_size = sz; r1_addr = a; r1_wdata = wd;
        @(posedge clk);
        #1 r1_req = 1'b0;
        lat = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (r1_done) seen = 1;
        end
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_fault"}, {31'h0, r1_fault}, {31'h0, exp_fault});
        check({tag, "_rdata"}, r1_rdata, exp_rd);
        @(negedge clk);
        check({tag, "_donew"}, {31'h0, r1_done}, 32'h0);
    endtask

    initial begin
        logic [5:0]  pat0;
        logic [12:0] pat3;
        int          ndone;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, r1_ready}, 32'h1);
        check("rst_done",  {31'h0, r1_done},  32'h0);
        check("rst_fault", {31'h0, r1_fault}, 32'h0);
        check("rst_rdata", r1_rdata, 32'h0);
        rst = 1'b0;

        acc1("wr_w10",  1'b1, 2'b10, 14'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        acc1("rd_w10",  1'b0, 2'b10, 14'h10, 32'h0,        1'b0, 32'hDEADBEEF);
        acc1("wr_b12",  1'b1, 2'b00, 14'h12, 32'hFFFFFF55, 1'b0, 32'hDEADBEEF);
        acc1("rd_w10b", 1'b0, 2'b10, 14'h10, 32'h0,        1'b0, 32'hDE55BEEF);
        acc1("rd_h12",  1'b0, 2'b01, 14'h12, 32'h0,        1'b0, 32'h0000DE55);
        acc1("rd_h10",  1'b0, 2'b01, 14'h10, 32'h0,        1'b0, 32'h0000BEEF);
        acc1("rd_b13",  1'b0, 2'b00, 14'h13, 32'h0,        1'b0, 32'h000000DE);
        acc1("wr_w11f", 1'b1, 2'b10, 14'h11, 32'h12345678, 1'b1, 32'h000000DE);
        acc1("rd_h13f", 1'b0, 2'b01, 14'h13, 32'h0,        1'b1, 32'h000000DE);
        acc1("rd_w10c", 1'b0, 2'b10, 14'h10, 32'h0,        1'b0, 32'hDE55BEEF);
        acc1("rd_rsvf", 1'b0, 2'b11, 14'h10, 32'h0,        1'b1, 32'hDE55BEEF);
        acc1("rd_b10",  1'b0, 2'b00, 14'h10, 32'h0,        1'b0, 32'h000000EF);

        acc1("wr_w14",  1'b1, 2'b10, 14'h14, 32'h00000000, 1'b0, 32'h000000EF);
        acc1("wr_h16",  1'b1, 2'b01, 14'h16, 32'h9ABC1234, 1'b0, 32'h000000EF);
        acc1("rd_w14",  1'b0, 2'b10, 14'h14, 32'h0,        1'b0, 32'h12340000);
        acc1("wr_top",  1'b1, 2'b10, 14'h3FFC, 32'hCAFEF00D, 1'b0, 32'h12340000);
        acc1("wr_w0",   1'b1, 2'b10, 14'h0000, 32'h11223344, 1'b0, 32'h12340000);
        acc1("rd_top",  1'b0, 2'b10, 14'h3FFC, 32'h0,        1'b0, 32'hCAFEF00D);
        acc1("rd_w0",   1'b0, 2'b10, 14'h0000, 32'h0,        1'b0, 32'h11223344);

        // A request raised during WAIT must be dropped, not queued.
        @(negedge clk);
        r1_req = 1'b1; r1_we = 1'b0; r1_size = 2'b10; r1_addr = 14'h10;
        @(posedge clk);
        #1 r1_we = 1'b1; r1_wdata = 32'h0;
        @(negedge clk);
        check("wait_ready", {31'h0, r1_ready}, 32'h0);
        @(posedge clk);
        #1 r1_req = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (r1_done) ndone++;
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        acc1("rd_ign",  1'b0, 2'b10, 14'h10, 32'h0,        1'b0, 32'hDE55BEEF);

        acc1("wr_w20",  1'b1, 2'b10, 14'h20, 32'h0BADC0DE, 1'b0, 32'hDE55BEEF);
        @(negedge clk);
        r1_req = 1'b1; r1_we = 1'b1; r1_size = 2'b10; r1_addr = 14'h20; r1_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1 r1_req = 1'b0;
        rst = 1'b1;
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (r1_done) ndone++;
        end
        check("rst_abort_done", 32'(ndone), 32'd0);
        rst = 1'b0;
        acc1("rd_w20",  1'b0, 2'b10, 14'h20, 32'h0,        1'b0, 32'h0BADC0DE);

        @(negedge clk);
        r0_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 if (i == 3) r0_req = 1'b0;
            @(negedge clk);
            pat0[i] = r0_done;
        end
        check("ws0_done_pat", {26'h0, pat0}, 32'h0000000F);

        @(negedge clk);
        r3_req = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1 if (i == 8) r3_req = 1'b0;
            @(negedge clk);
            pat3[i] = r3_done;
        end
        check("ws3_done_pat", {19'h0, pat3}, 32'h00000888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wait_state_ram.md
WAIT_STATE_RAM -- requirements
Module: wait_state_ram

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 14: byte-address width; depth is 2^(ADDR_WIDTH-2) words.
REQ-002 The module SHALL have parameter WAIT_STATES, default 1: extra cycles per access, legal range 0..15.
REQ-003 The data width SHALL be fixed at 32 bits, organised as 4 byte lanes in little-endian order (lane 0 = bits 7:0).
REQ-004 Port clk SHALL be an input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-006 Port req SHALL be an input, 1 bit: access request, sampled only while ready=1.
REQ-007 Port we SHALL be an input, 1 bit: 1 = write, 0 = read.
REQ-008 Port size SHALL be an input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-009 Port addr SHALL be an input, ADDR_WIDTH bits: byte address.
REQ-010 Port wdata SHALL be an input, 32 bits: write data, right-justified for byte and halfword accesses.
REQ-011 Port rdata SHALL be an output, 32 bits: read data, zero-extended and right-justified.
REQ-012 Port ready SHALL be an output, 1 bit: the block can accept a request this cycle.
REQ-013 Port done SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-014 Port fault SHALL be an output, 1 bit: valid only with done; flags a misaligned or reserved-size access.

Function
REQ-015 A request SHALL be accepted on a rising edge where req=1 and ready=1; addr, we, size and wdata are captured on that edge.
REQ-016 The FSM SHALL have three states: IDLE (ready=1), WAIT (ready=0, counting down WAIT_STATES), RESP (done=1, ready=1).
REQ-017 On acceptance, the FSM SHALL move to WAIT if WAIT_STATES>0, otherwise directly to RESP.
REQ-018 In WAIT, the FSM SHALL move to RESP after exactly WAIT_STATES cycles.
REQ-019 done SHALL be high for exactly one cycle, 1+WAIT_STATES cycles after the acceptance edge.
REQ-020 The memory write and the rdata update SHALL occur on the edge that enters RESP.
REQ-021 In RESP, a new request with req=1 SHALL be accepted (back-to-back throughput of one access per 1+WAIT_STATES cycles); if req=0 the FSM SHALL return to IDLE.
REQ-022 A byte write SHALL update only lane addr[1:0].
REQ-023 A halfword write SHALL update lanes {addr[1],0} and {addr[1],1}.
REQ-024 A word write SHALL update all 4 lanes.
REQ-025 A read SHALL return the selected lane(s) shifted down to bit 0, with the upper bits zero.
REQ-026 A halfword access with addr[0]=1, a word access with addr[1:0]!=0, or size=11 SHALL be faulted.
REQ-027 A faulted access SHALL write no memory, SHALL leave rdata unchanged, and SHALL produce done=1 with fault=1.
REQ-028 fault SHALL be 0 whenever done=0.
REQ-029 rdata SHALL hold its value until the next successful read completes; writes SHALL NOT alter rdata.
REQ-030 req asserted while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-031 Word index addr[ADDR_WIDTH-1:2] SHALL address the full depth with no wrap between words.

Reset
REQ-032 While rst=1, the outputs SHALL be: ready=1, done=0, fault=0, rdata=0, and the FSM SHALL be in IDLE with the wait counter at 0.
REQ-033 rst asserted mid-access SHALL abort the access with no memory write and no done pulse.
REQ-034 Memory array contents SHALL NOT be reset.

Structure
REQ-035 Package wsr_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and a lane-enable function of size and addr[1:0].
REQ-036 The block SHALL use one sub-module, ram_lane: an 8-bit wide, 2^(ADDR_WIDTH-2)-deep synchronous RAM with its own write enable, instantiated 4 times.

Verification
REQ-037 With WAIT_STATES=1, word write 0xDEADBEEF to addr 0x10, then a word read of 0x10 SHALL give done 2 cycles after each acceptance and rdata=0xDEADBEEF.
REQ-038 After REQ-037, a byte write of 0x55 to 0x12 followed by a word read of 0x10 SHALL give rdata=0xDE55BEEF.
REQ-039 After REQ-038, halfword reads of 0x12 and 0x10 SHALL give 0x0000DE55 and 0x0000BEEF; a byte read of 0x13 SHALL give 0x000000DE.
REQ-040 A word write to 0x11 and a halfword read of 0x13 SHALL each produce done=1 with fault=1; a later read of 0x10 SHALL be unchanged and rdata SHALL hold its prior value.
REQ-041 With WAIT_STATES=0 and req held high for 4 back-to-back word reads, done SHALL be high on 4 consecutive cycles; with WAIT_STATES=3, done SHALL fall every 4th cycle.
REQ-042 Asserting rst in the WAIT state of a write to 0x20 SHALL produce no done pulse, and a later read of 0x20 SHALL return the pre-write data.
